gpio_input_capture: RTL
=======================

GPIO_INPUT_CAPTURE -- requirements
Module: gpio_input_capture

Interface
REQ-001 SHALL have parameter N, default 15, index of the port MSB (port width N+1).
REQ-002 SHALL have parameter DB_CYCLES, default 4, debounce qualification length in clocks (range 2..255).
REQ-003 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_pin_states, input, N+1, asynchronous logic levels present at the GPIO pins.
REQ-006 SHALL have port i_data_dir, input, N+1, per-bit direction; 1 = output (capture disabled), 0 = input.
REQ-007 SHALL have port i_rise_en, input, N+1, per-bit rising-edge event enable.
REQ-008 SHALL have port i_fall_en, input, N+1, per-bit falling-edge event enable.
REQ-009 SHALL have port i_pend_clr, input, N+1, per-bit clear of the pending register, sampled each clock.
REQ-010 SHALL have port o_data_received, output, N+1, qualified (synchronized, optionally debounced) pin state.
REQ-011 SHALL have port o_pending, output, N+1, sticky edge-event flags.
REQ-012 SHALL have port o_irq, output, 1, OR-reduction of o_pending (combinational from registers).

Function
REQ-013 SHALL pass every pin through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 SHALL keep a per-bit stable-state register; o_data_received = stable AND NOT i_data_dir.
REQ-015 SHALL, for input bits without debounce, load stable from sync2 every clock: pin change to o_data_received latency = 3 clocks.
REQ-016 SHALL, for output bits (dir=1), load stable from sync2 each clock, hold the debounce counter at 0, and generate no events, so a switch from output to input causes no spurious edge.
REQ-017 SHALL flag a rising event when sync2=1, stable=0 and the stable update commits; falling event when sync2=0, stable=1.
REQ-018 SHALL set pending bit on the same edge stable changes when the matching enable bit is 1; disabled edges update stable but set nothing.
REQ-019 SHALL clear a pending bit when its i_pend_clr bit is 1; a simultaneous set and clear on the same bit SHALL leave it set.
REQ-020 SHALL retain an already-set pending bit when its enable is deasserted or its direction becomes output.
REQ-021 SHALL assert o_irq in the same cycle any o_pending bit is 1, with no additional register stage.

Reset
REQ-022 SHALL, on a clock edge with i_rst=1, clear sync1, sync2, stable, all debounce counters and o_pending to 0; o_data_received=0 and o_irq=0 the following cycle.
REQ-023 SHALL treat reset as dominant over clear, set and debounce activity; an edge in progress at reset is discarded.
REQ-024 SHALL produce no events from the first post-reset samples unless a pin differs from the reset stable value 0 (a pin held high at reset release produces one rising event if enabled).

Configuration
REQ-025 SHALL compile per-bit debounce logic only when macro GPIO_INPUT_DEBOUNCE_EN is defined.
REQ-026 SHALL, with GPIO_INPUT_DEBOUNCE_EN defined, increment a per-bit counter each clock sync2 != stable, reset it to 0 when sync2 == stable, and load stable (counter to 0) when the counter reaches DB_CYCLES-1 while still differing: latency 2+DB_CYCLES clocks; glitches shorter than DB_CYCLES clocks are ignored.
REQ-027 SHALL, without the macro, contain no counters, ignore DB_CYCLES, and behave per REQ-015.

Verification
REQ-028 SHALL cover: reset, dir=0x0000, pins 0x0000->0x00A5 with rise_en=0xFFFF, no debounce -> o_data_received=0x00A5 3 clocks later, o_pending=0x00A5, o_irq=1 same cycle.
REQ-029 SHALL cover: pending=0x0001, i_pend_clr=0x0001 on the same clock bit0 falls with fall_en=0x0001 -> o_pending stays 0x0001.
REQ-030 SHALL cover: dir=0xFF00, pins toggled 0xFFFF<->0x0000 with all enables set -> o_data_received upper byte 0x00, o_pending upper byte never sets; then dir=0x0000 -> no event on switch.
REQ-031 SHALL cover (GPIO_INPUT_DEBOUNCE_EN, DB_CYCLES=4): bit3 high for 3 clocks -> no change; high for 4+ clocks -> o_data_received bit3=1 at clock 6 after the pin change.
REQ-032 SHALL cover: i_rst asserted mid-debounce with pending=0x8000 -> next cycle all outputs 0, no later event from the aborted edge.

Source files
------------

// File: rtl/gpio_input_capture.sv
// gpio_input_capture
//   Synchronizes, optionally debounces and edge-detects a bank of N+1 GPIO
//   input pins. Detected edges that are enabled set sticky pending flags.
//   o_irq is the OR of all pending flags.
//
// Parameters
//   N          index of the port MSB (port width N+1)
//   DB_CYCLES  debounce qualification length in clocks (2..255). Only used
//              when GPIO_INPUT_DEBOUNCE_EN is defined.
//
// Build option
//   GPIO_INPUT_DEBOUNCE_EN  when defined, compiles a per-bit debounce counter.
//                           A new level must then be held for DB_CYCLES clocks
//                           before it is accepted. When undefined, the
//                           synchronized level is accepted every clock.
//
// Ports
//   i_clk            single clock, rising edge
//   i_rst            synchronous active-high reset
//   i_pin_states     asynchronous pin levels
//   i_data_dir       per-bit direction, 1 = output (capture disabled)
//   i_rise_en        per-bit rising-edge event enable
//   i_fall_en        per-bit falling-edge event enable
//   i_pend_clr       per-bit pending clear, sampled every clock
//   o_data_received  qualified pin state, forced to 0 on output bits
//   o_pending        sticky edge-event flags
//   o_irq            OR of o_pending
module gpio_input_capture #(
   parameter int unsigned N         = 15,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N:0]   i_pin_states,
   input  logic [N:0]   i_data_dir,
   input  logic [N:0]   i_rise_en,
   input  logic [N:0]   i_fall_en,
   input  logic [N:0]   i_pend_clr,
   output logic [N:0]   o_data_received,
   output logic [N:0]   o_pending,
   output logic         o_irq
);

   if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db_cycles
      $error("gpio_input_capture: DB_CYCLES must be in 2..255");
   end

   logic [N:0] r_sync1;
   logic [N:0] r_sync2;
   logic [N:0] r_stable;
   logic [N:0] r_pending;
   logic [N:0] w_commit;   // input bit whose stable level changes this clock
   logic [N:0] w_rise;
   logic [N:0] w_fall;

`ifdef GPIO_INPUT_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DB_CYCLES);

   logic [CW-1:0] r_cnt [N+1];

   always_comb begin
      w_commit = '0;
      for (int unsigned i = 0; i < N + 1; i++) begin
         w_commit[i] = !i_data_dir[i] && (r_sync2[i] != r_stable[i]) &&
                       (r_cnt[i] == CW'(DB_CYCLES - 1));
      end
   end

   // Output bits track the pin directly with the counter parked at 0, so a
   // later switch to input starts from an already-agreeing stable value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stable <= '0;
         for (int unsigned i = 0; i < N + 1; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N + 1; i++) begin
            if (i_data_dir[i]) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i]    <= '0;
            end else if (w_commit[i]) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i]    <= r_cnt[i] + CW'(1);
            end
         end
      end
   end
`else
   always_comb begin
      w_commit = ~i_data_dir & (r_sync2 ^ r_stable);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stable <= '0;
      end else begin
         r_stable <= r_sync2;
      end
   end
`endif

   // A commit only happens when sync2 differs from stable, so sync2 alone
   // tells the edge direction.
   always_comb begin
      w_rise = w_commit & r_sync2;
      w_fall = w_commit & ~r_sync2;
   end

   // Set terms are ORed after the clear so a simultaneous set wins.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_pending <= '0;
      end else begin
         r_sync1   <= i_pin_states;
         r_sync2   <= r_sync1;
         r_pending <= (r_pending & ~i_pend_clr) |
                      (w_rise & i_rise_en) |
                      (w_fall & i_fall_en);
      end
   end

   assign o_data_received = r_stable & ~i_data_dir;
   assign o_pending       = r_pending;
   assign o_irq           = |r_pending;

endmodule
